bip2_control: RTL

Multicycle control unit for the BIP-2 datapath: fetches 16-bit instructions from program ROM, decodes them, and drives the accumulator write enable, operand/ALU selects and data-RAM write. It is the producer of the accumulator's write strobe and the consumer of ALU results for the STATUS flags. Sits between program ROM, data RAM, the ALU and the accumulator register; each instruction takes three clocks.

---
 rtl/bip2_control.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/bip2_control.sv
// bip2_control: multicycle control unit for the BIP-2 datapath.
// Fetches 16-bit instructions from combinational program ROM, decodes them and
// drives accumulator/RAM write strobes, operand/ALU selects, the STATUS flags
// and the program counter. Every instruction takes three clocks.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// S_FETCH  | IR captures rom_data_i at pc_o; all strobes low
// S_DECODE | IR fields and selects valid; synchronous RAM read completes
// S_EXEC   | one-cycle WrAcc/WrRam strobe; flags and PC update on leaving
// S_HALT   | absorbing after HLT; pc_o frozen, strobes low, halted_o high

module bip2_control #(
    parameter int MSB_ROM = 11,
    parameter int LSB     = 0,
    parameter int OPC_W   = 5
) (
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic [OPC_W+MSB_ROM-1:LSB]   rom_data_i,
    input  logic [MSB_ROM-1:LSB]         alu_result_i,
    output logic [MSB_ROM-1:LSB]         pc_o,
    output logic [MSB_ROM-1:LSB]         ram_addr_o,
    output logic [MSB_ROM-1:LSB]         operand_o,
    output logic                         WrAcc,
    output logic                         WrRam,
    output logic [1:0]                   SelA,
    output logic                         SelB,
    output logic                         Op,
    output logic                         flag_z_o,
    output logic                         flag_n_o,
    output logic                         halted_o
);

    localparam int IW = OPC_W + MSB_ROM;

    localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;
    localparam logic [OPC_W-1:0] OP_BEQ  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_BNE  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_BGT  = 5'b01010;
    localparam logic [OPC_W-1:0] OP_BGE  = 5'b01011;
    localparam logic [OPC_W-1:0] OP_BLT  = 5'b01100;
    localparam logic [OPC_W-1:0] OP_BLE  = 5'b01101;
    localparam logic [OPC_W-1:0] OP_JMP  = 5'b01110;

    localparam logic [1:0] SEL_A_RAM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    localparam logic [MSB_ROM-1:0] PC_ONE = {{(MSB_ROM-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t               state, state_next;
    logic [IW-1:0]        ir, ir_next;
    logic [MSB_ROM-1:0]   pc, pc_next;
    logic                 flag_z, flag_z_next;
    logic                 flag_n, flag_n_next;

    logic [OPC_W-1:0]     opcode;
    logic [MSB_ROM-1:0]   operand;

    logic                 dec_acc_wr;
    logic                 dec_ram_wr;
    logic                 dec_arith;
    logic                 dec_hlt;
    logic                 dec_taken;
    logic [1:0]           dec_sel_a;
    logic                 dec_sel_b;
    logic                 dec_op;

    assign opcode  = ir[IW-1:MSB_ROM];
    assign operand = ir[MSB_ROM-1:0];

    // Instruction decode from IR: strobe classes, selects and branch decision.
    always_comb begin
        dec_acc_wr = 1'b0;
        dec_ram_wr = 1'b0;
        dec_arith  = 1'b0;
        dec_hlt    = 1'b0;
        dec_taken  = 1'b0;
        dec_sel_a  = SEL_A_RAM;
        dec_sel_b  = 1'b0;
        dec_op     = 1'b0;
        unique case (opcode)
            OP_HLT:  dec_hlt = 1'b1;
            OP_STO:  dec_ram_wr = 1'b1;
            OP_LD: begin
                dec_acc_wr = 1'b1;
                dec_sel_a  = SEL_A_RAM;
            end
            OP_LDI: begin
                dec_acc_wr = 1'b1;
                dec_sel_a  = SEL_A_IMM;
            end
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                dec_acc_wr = 1'b1;
                dec_arith  = 1'b1;
                dec_sel_a  = SEL_A_ALU;
                // Bit 0 of the opcode distinguishes the immediate form,
                // bit 1 distinguishes subtract.
                dec_sel_b  = opcode[0];
                dec_op     = opcode[1];
            end
            OP_BEQ:  dec_taken = flag_z;
            OP_BNE:  dec_taken = !flag_z;
            OP_BGT:  dec_taken = !flag_z && !flag_n;
            OP_BGE:  dec_taken = !flag_n;
            OP_BLT:  dec_taken = flag_n;
            OP_BLE:  dec_taken = flag_n || flag_z;
            OP_JMP:  dec_taken = 1'b1;
            default: ;
        endcase
    end

    // Next-state, register-next values and control outputs.
    always_comb begin
        state_next  = state;
        ir_next     = ir;
        pc_next     = pc;
        flag_z_next = flag_z;
        flag_n_next = flag_n;
        WrAcc       = 1'b0;
        WrRam       = 1'b0;
        SelA        = SEL_A_RAM;
        SelB        = 1'b0;
        Op          = 1'b0;
        halted_o    = 1'b0;
        case (state)
            S_FETCH: begin
                ir_next    = rom_data_i;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                SelA       = dec_sel_a;
                SelB       = dec_sel_b;
                Op         = dec_op;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                SelA  = dec_sel_a;
                SelB  = dec_sel_b;
                Op    = dec_op;
                WrAcc = dec_acc_wr;
                WrRam = dec_ram_wr;
                if (dec_arith) begin
                    flag_z_next = (alu_result_i == '0);
                    flag_n_next = alu_result_i[MSB_ROM-1];
                end
                if (dec_hlt) begin
                    state_next = S_HALT;
                end else begin
                    pc_next    = dec_taken ? operand : pc + PC_ONE;
                    state_next = S_FETCH;
                end
            end
            S_HALT: begin
                halted_o = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // State, instruction, PC and STATUS registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state  <= S_FETCH;
            ir     <= '0;
            pc     <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            state  <= state_next;
            ir     <= ir_next;
            pc     <= pc_next;
            flag_z <= flag_z_next;
            flag_n <= flag_n_next;
        end
    end

    assign pc_o       = pc;
    assign ram_addr_o = operand;
    assign operand_o  = operand;
    assign flag_z_o   = flag_z;
    assign flag_n_o   = flag_n;

endmodule
